seg_data_gen: RTL and testbench
===============================

SEG_DATA_GEN -- requirements
Module: seg_data_gen

Interface
REQ-001 Parameter CNT_MAX, default 5_000_000, is the number of sys_clk cycles per step (100 ms at 50 MHz); legal values are 2 or more.
REQ-002 Parameter DATA_MAX, default 999_999, is the maximum displayed magnitude; it SHALL be less than 2^DATA_W.
REQ-003 Parameter DATA_W, default 20, is the width of the data and load_val ports.
REQ-004 Parameter DIGITS, default 6, is the digit count and sets the width of point.
REQ-005 Parameter POINT, default all zeros, DIGITS bits, is the decimal-point pattern driven after reset.
REQ-006 sys_clk  in  1  Single clock for the whole block.
REQ-007 sys_rst  in  1  Synchronous, active-high reset.
REQ-008 mode  in  2  00 = UP, 01 = DOWN, 10 = BIPOLAR, 11 = HOLD.
REQ-009 pause  in  1  While high, freezes both the prescaler and the value.
REQ-010 load  in  1  Synchronous load strobe.
REQ-011 load_val  in  DATA_W  Magnitude to load.
REQ-012 load_sign  in  1  Sign to load; 1 = negative.
REQ-013 data  out  DATA_W  Magnitude of the value.
REQ-014 point  out  DIGITS  Decimal-point enables.
REQ-015 sign  out  1  1 = value negative.
REQ-016 seg_en  out  1  Display enable.
REQ-017 step  out  1  One-cycle pulse marking each value update.

Function
REQ-018 The prescaler cnt SHALL count 0..CNT_MAX-1 and wrap, advancing only when pause=0.
REQ-019 step SHALL be a registered pulse, high for one cycle on the edge after cnt==CNT_MAX-1 with pause=0; one pulse every CNT_MAX unpaused cycles.
REQ-020 The value (sign, data) SHALL update on the edge where step=1 and pause=0, so data changes one cycle after the step pulse.
REQ-021 UP mode SHALL advance data 0,1,...,DATA_MAX,0 (wrap) with sign=0.
REQ-022 DOWN mode SHALL advance data DATA_MAX,...,1,0,DATA_MAX (wrap) with sign=0.
REQ-023 In UP or DOWN mode with sign=1, the next update SHALL set data=0 and sign=0.
REQ-024 BIPOLAR mode SHALL sweep the signed value v between -DATA_MAX and +DATA_MAX in steps of 1, ping-ponging under an internal dir flag.
REQ-025 In BIPOLAR mode, dir SHALL flip to down on the step where v reaches +DATA_MAX and to up where v reaches -DATA_MAX; the next step moves away from the bound, so no bound value repeats.
REQ-026 data SHALL always equal |v|; sign SHALL be 1 only for v<0; zero SHALL always be output with sign=0.
REQ-027 HOLD mode SHALL leave the value and dir unchanged while step keeps pulsing.
REQ-028 A mode change SHALL take effect at the next update; dir is retained across mode changes.
REQ-029 load=1 SHALL, on that edge, set data=min(load_val, DATA_MAX) and clear cnt to 0, overriding any same-cycle step and overriding pause.
REQ-030 On load, sign SHALL take load_sign, except that it SHALL be 0 when the loaded magnitude is 0.
REQ-031 A load SHALL produce no step pulse; the next step comes CNT_MAX unpaused cycles later.
REQ-032 pause=1 SHALL hold cnt, step=0 and the value; on release the count resumes from the held cnt.
REQ-033 point SHALL equal POINT and seg_en SHALL equal 1 on every cycle outside reset.

Reset
REQ-034 While sys_rst=1 at a clock edge, cnt, data, sign, step, point and seg_en SHALL all be 0 and dir SHALL be up.
REQ-035 Asserting reset mid-sweep, mid-pause or during a load SHALL override everything, with reset taking priority over load.
REQ-036 On the first edge after reset is released, seg_en=1 and point=POINT; the first step pulse follows CNT_MAX cycles after release.

Verification (CNT_MAX=4, DATA_MAX=9, DATA_W=4, DIGITS=6, POINT=6'b000100)
REQ-037 Reset: hold sys_rst high 3 cycles, then release with mode=00 -> all outputs 0 during reset; seg_en=1 and point=000100 next cycle; step pulses every 4 cycles; data runs 1,2,...,9,0.
REQ-038 DOWN wrap: mode=01 from reset -> data 9,8,...,0,9; sign stays 0.
REQ-039 BIPOLAR: load 9 with load_sign=1, then mode=10 -> sign/data run -9,-8,...,-1,0(sign 0),1,...,9,8; sign=1 only on the negative values.
REQ-040 Load and pause: load_val=15 -> data=9; load in the same cycle as step -> loaded value kept and cnt=0; pause for 10 cycles -> no step and no change; release -> remaining count resumes.
REQ-041 Mode edges: in BIPOLAR at -3, switch to UP -> next update 0 with sign 0, then 1; assert sys_rst at data=5 -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/seg_data_gen.sv
// Stepping value generator for a seven-segment display: prescaled up/down/bipolar
// counter with load, pause and hold, producing sign/magnitude plus display controls.
module seg_data_gen #(
  parameter int                 CNT_MAX  = 5_000_000,
  parameter int                 DATA_MAX = 999_999,
  parameter int                 DATA_W   = 20,
  parameter int                 DIGITS   = 6,
  parameter logic [DIGITS-1:0]  POINT    = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              load_sign,
  output logic [DATA_W-1:0] data,
  output logic [DIGITS-1:0] point,
  output logic              sign,
  output logic              seg_en,
  output logic              step
);

  localparam int                      CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [DATA_W-1:0]       DMAX     = DATA_W'(DATA_MAX);
  localparam logic signed [DATA_W:0]  VMAX     = (DATA_W + 1)'(DATA_MAX);
  localparam logic signed [DATA_W:0]  VMIN     = -VMAX;
  localparam logic signed [DATA_W:0]  ONE      = (DATA_W + 1)'(1);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_BIP  = 2'b10;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sign_q, sign_d;
  logic              step_q, step_d;
  logic              dir_up_q, dir_up_d;
  logic [DIGITS-1:0] point_q;
  logic              seg_en_q;

  logic [DATA_W-1:0]      load_mag;
  logic signed [DATA_W:0] v_cur, v_nxt, v_abs;
  logic                   up_move;

  always_comb begin
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    data_d   = data_q;
    sign_d   = sign_q;
    dir_up_d = dir_up_q;
    load_mag = (load_val > DMAX) ? DMAX : load_val;

    // Bipolar sweep is computed in two's complement; a wrong-way dir at a bound
    // (possible after a load) still moves away from that bound.
    v_cur = {1'b0, data_q};
    if (sign_q) begin
      v_cur = -v_cur;
    end
    up_move = (dir_up_q && (v_cur != VMAX)) || (v_cur == VMIN);
    v_nxt   = up_move ? (v_cur + ONE) : (v_cur - ONE);
    v_abs   = v_nxt[DATA_W] ? -v_nxt : v_nxt;

    if (load) begin
      cnt_d  = '0;
      data_d = load_mag;
      sign_d = load_sign && (load_mag != '0);
    end else if (!pause) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      step_d = (cnt_q == CNT_LAST);
      if (step_q) begin
        case (mode)
          MODE_UP: begin
            data_d = (sign_q || data_q == DMAX) ? '0 : data_q + 1'b1;
            sign_d = 1'b0;
          end
          MODE_DOWN: begin
            if (sign_q) begin
              data_d = '0;
            end else begin
              data_d = (data_q == '0) ? DMAX : data_q - 1'b1;
            end
            sign_d = 1'b0;
          end
          MODE_BIP: begin
            data_d   = v_abs[DATA_W-1:0];
            sign_d   = v_nxt[DATA_W];
            dir_up_d = (v_nxt == VMAX) ? 1'b0 : (v_nxt == VMIN) ? 1'b1 : up_move;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q    <= '0;
      data_q   <= '0;
      sign_q   <= 1'b0;
      step_q   <= 1'b0;
      dir_up_q <= 1'b1;
      point_q  <= '0;
      seg_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      sign_q   <= sign_d;
      step_q   <= step_d;
      dir_up_q <= dir_up_d;
      point_q  <= POINT;
      seg_en_q <= 1'b1;
    end
  end

  assign data   = data_q;
  assign sign   = sign_q;
  assign step   = step_q;
  assign point  = point_q;
  assign seg_en = seg_en_q;

endmodule

// File: tb/tb_seg_data_gen.sv
// Directed bench for seg_data_gen: a signed-integer model checked every cycle,
// plus literal expectations for reset, wraps, bipolar sweep, load and pause.
module tb_seg_data_gen;

  localparam int         CNT_MAX  = 4;
  localparam int         DATA_MAX = 9;
  localparam int         DATA_W   = 4;
  localparam int         DIGITS   = 6;
  localparam logic [5:0] POINT    = 6'b000100;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic              pause = 1'b0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] load_val = '0;
  logic              load_sign = 1'b0;
  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] point;
  logic              sign;
  logic              seg_en;
  logic              step;

  always #5 sys_clk = ~sys_clk;

  seg_data_gen #(
    .CNT_MAX(CNT_MAX), .DATA_MAX(DATA_MAX), .DATA_W(DATA_W), .DIGITS(DIGITS), .POINT(POINT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .pause(pause), .load(load),
    .load_val(load_val), .load_sign(load_sign), .data(data), .point(point),
    .sign(sign), .seg_en(seg_en), .step(step)
  );

  // Model: prescaler position, pending-step flag and the displayed value as a signed int.
  int m_cnt = 0;
  int m_v = 0;
  int m_mag = 0;
  bit m_step = 0;
  bit m_up = 1;
  bit m_on = 0;
  bit m_upd = 0;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_cnt = 0; m_v = 0; m_step = 0; m_up = 1; m_on = 0;
    end else begin
      m_on = 1;
      if (load) begin
        m_mag  = (int'(load_val) > DATA_MAX) ? DATA_MAX : int'(load_val);
        m_v    = load_sign ? -m_mag : m_mag;
        m_cnt  = 0;
        m_step = 0;
      end else if (!pause) begin
        m_upd  = m_step;
        m_step = (m_cnt == CNT_MAX - 1);
        m_cnt  = (m_cnt + 1) % CNT_MAX;
        if (m_upd) begin
          case (mode)
            2'b00: m_v = (m_v < 0 || m_v == DATA_MAX) ? 0 : m_v + 1;
            2'b01: m_v = (m_v < 0) ? 0 : ((m_v == 0) ? DATA_MAX : m_v - 1);
            2'b10: begin
              if (m_v == DATA_MAX) m_up = 0;
              if (m_v == -DATA_MAX) m_up = 1;
              m_v = m_up ? m_v + 1 : m_v - 1;
              if (m_v == DATA_MAX) m_up = 0;
              if (m_v == -DATA_MAX) m_up = 1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sval();
    return sign ? -int'(data) : int'(data);
  endfunction

  // Every cycle ends here, so the model comparison runs on each falling edge.
  task automatic tick();
    @(negedge sys_clk);
    check("model_data", int'(data), (m_v < 0) ? -m_v : m_v);
    check("model_sign", int'(sign), int'(m_v < 0));
    check("model_step", int'(step), int'(m_step));
    check("model_seg_en", int'(seg_en), int'(m_on));
    check("model_point", int'(point), m_on ? int'(POINT) : 0);
  endtask

  task automatic wait_step(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step && n < 3 * CNT_MAX);
    if (!step) check({name, "_step_timeout"}, 0, 1);
  endtask

  task automatic watch(input string name);
    int n;
    foreach (exp_q[i]) begin
      wait_step(name, n);
      tick();
      check($sformatf("%s[%0d]", name, i), sval(), exp_q[i]);
    end
  endtask

  task automatic do_reset(input int cycles);
    sys_rst = 1'b1; load = 1'b0; pause = 1'b0;
    repeat (cycles) tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    int n;
    int steps_seen;

    // Reset, then UP wrap
    mode = 2'b00;
    repeat (3) begin
      tick();
      check("rst_data", int'(data), 0);
      check("rst_seg_en", int'(seg_en), 0);
      check("rst_point", int'(point), 0);
      check("rst_step", int'(step), 0);
    end
    sys_rst = 1'b0;
    tick();
    check("rel_seg_en", int'(seg_en), 1);
    check("rel_point", int'(point), 6'b000100);
    wait_step("first", n);
    check("first_step_latency", n + 1, 4);
    tick();
    check("up_first", sval(), 1);
    exp_q = {2, 3, 4, 5, 6, 7, 8, 9, 0};
    watch("up");

    // DOWN wrap from reset
    mode = 2'b01;
    do_reset(2);
    exp_q = {9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    watch("down");

    // BIPOLAR sweep from -9, then HOLD keeps value and dir
    do_reset(2);
    load = 1'b1; load_val = 4'd9; load_sign = 1'b1; mode = 2'b10;
    tick();
    load = 1'b0;
    check("bip_load", sval(), -9);
    exp_q = {-8, -7, -6, -5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 8};
    watch("bip");
    mode = 2'b11;
    exp_q = {8, 8};
    watch("hold");
    mode = 2'b10;
    exp_q = {7};
    watch("bip_resume");

    // Load clamp, zero load sign, load on step, pause
    mode = 2'b00;
    load = 1'b1; load_val = 4'd15; load_sign = 1'b0;
    tick();
    check("load_clamp", sval(), 9);
    load_val = 4'd0; load_sign = 1'b1;
    tick();
    check("load_zero_sign", int'(sign), 0);
    load = 1'b0;
    wait_step("pre_load", n);
    load = 1'b1; load_val = 4'd3; load_sign = 1'b0;
    tick();
    load = 1'b0;
    check("load_over_step", sval(), 3);
    check("load_no_step", int'(step), 0);
    wait_step("after_load", n);
    check("load_restart", n, 4);
    tick();
    check("after_load_up", sval(), 4);
    pause = 1'b1;
    steps_seen = 0;
    repeat (10) begin
      tick();
      if (step) steps_seen++;
    end
    check("pause_steps", steps_seen, 0);
    check("pause_data", sval(), 4);
    pause = 1'b0;
    wait_step("resume", n);
    check("pause_resume", n, 3);
    tick();
    check("resume_up", sval(), 5);

    // Mode change from BIPOLAR to UP, reset mid-sweep, reset beats load
    do_reset(2);
    mode = 2'b10;
    load = 1'b1; load_val = 4'd4; load_sign = 1'b1;
    tick();
    load = 1'b0;
    exp_q = {-3};
    watch("bip_m3");
    mode = 2'b00;
    exp_q = {0, 1, 2, 3, 4, 5};
    watch("bip_to_up");
    sys_rst = 1'b1;
    tick();
    check("midrst_data", int'(data), 0);
    check("midrst_sign", int'(sign), 0);
    check("midrst_seg_en", int'(seg_en), 0);
    check("midrst_point", int'(point), 0);
    load = 1'b1; load_val = 4'd7;
    tick();
    check("rst_over_load", int'(data), 0);
    load = 1'b0; sys_rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
